// File: rtl/ysyx_25010008_pkg.sv
// ysyx_25010008_pkg: shared LSU state encodings, access size codes and byte-lane masks
package ysyx_25010008_pkg;

    typedef enum logic [2:0] {
        LSU_IDLE,
        LSU_AR,
        LSU_R,
        LSU_AW,
        LSU_W,
        LSU_B,
        LSU_RESP
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/ysyx_25010008_lsu_align.sv
// ysyx_25010008_lsu_align: store lane steering / strobe generation and load extract / extension
module ysyx_25010008_lsu_align
    import ysyx_25010008_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] rdata_o
);

    logic [4:0]  sh;
    logic [3:0]  base;
    logic [31:0] x;
    logic        s;

    assign sh = {off_i, 3'b000};

    // size code 3 falls through to the word cases
    always_comb begin
        base    = size_i == SZ_B ? MASK_B : size_i == SZ_H ? MASK_H : MASK_W;
        wstrb_o = base << off_i;
        wdata_o = wdata_i << sh;
        x       = rdata_i >> sh;
        s       = ~unsigned_i;
        rdata_o = size_i == SZ_B ? {{24{s & x[7]}}, x[7:0]} :
                  size_i == SZ_H ? {{16{s & x[15]}}, x[15:0]} : x;
    end

endmodule

// File: rtl/ysyx_25010008_lsu.sv
// ysyx_25010008_lsu: single-outstanding load/store unit bridging EXU requests onto AXI-lite
module ysyx_25010008_lsu
    import ysyx_25010008_pkg::*;
#(
    parameter bit MISALIGN_CHK    = 1'b1,
    parameter int RESET_PC_UNUSED = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [31:0] wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bresp,
    input  logic        bvalid,
    output logic        bready
);

    lsu_state_e  state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        wen_q;
    logic        err_q;
    logic [31:0] st_wdata;
    logic [31:0] ld_rdata;
    logic [3:0]  st_mask;
    logic        misaligned;
    logic        unused_pc;

    assign unused_pc  = ^RESET_PC_UNUSED;
    assign misaligned = MISALIGN_CHK && ((req_size == SZ_H && req_addr[0]) ||
                                         (req_size[1] && req_addr[1:0] != 2'b00));

    ysyx_25010008_lsu_align u_align (
        .off_i      (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .rdata_i    (rdata),
        .wdata_o    (st_wdata),
        .wstrb_o    (st_mask),
        .rdata_o    (ld_rdata)
    );

    // every bus-facing output decodes from registered state only
    assign req_ready  = state_q == LSU_IDLE;
    assign arvalid    = state_q == LSU_AR;
    assign rready     = state_q == LSU_R;
    assign awvalid    = state_q == LSU_AW;
    assign wvalid     = state_q == LSU_W;
    assign bready     = state_q == LSU_B;
    assign resp_valid = state_q == LSU_RESP;
    assign araddr     = {addr_q[31:2], 2'b00};
    assign awaddr     = {addr_q[31:2], 2'b00};
    assign wdata      = st_wdata;
    assign wstrb      = {28'b0, wen_q ? st_mask : 4'b0000};
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // transaction sequencer: latch request, walk the channel handshakes, hold response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LSU_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                LSU_IDLE: if (req_valid) begin
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    size_q  <= req_size;
                    uns_q   <= req_unsigned;
                    wen_q   <= req_wen;
                    rdata_q <= '0;
                    err_q   <= misaligned;
                    state_q <= misaligned ? LSU_RESP : (req_wen ? LSU_AW : LSU_AR);
                end
                LSU_AR: if (arready) state_q <= LSU_R;
                LSU_R: if (rvalid) begin
                    rdata_q <= ld_rdata;
                    err_q   <= rresp;
                    state_q <= LSU_RESP;
                end
                LSU_AW: if (awready) state_q <= LSU_W;
                LSU_W: if (wready) state_q <= LSU_B;
                LSU_B: if (bvalid) begin
                    err_q   <= bresp;
                    state_q <= LSU_RESP;
                end
                LSU_RESP: if (resp_ready) state_q <= LSU_IDLE;
                default: state_q <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25010008_lsu.sv
// tb_ysyx_25010008_lsu: scoreboard bench with directed vectors and a delay-programmable AXI-lite slave
module tb_ysyx_25010008_lsu;
    import ysyx_25010008_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] araddr, rdata, awaddr, wdata, wstrb;
    logic        arvalid, arready, rresp, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bresp, bvalid, bready;

    ysyx_25010008_lsu #(.MISALIGN_CHK(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          max_lat;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0, n_fail = 0;
    logic [31:0] exp_addr, exp_wdata, s_rdata;
    logic [3:0]  exp_wstrb;
    logic        s_resp;
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, resp_hold = 0;
    int          ar_seen = 0, aw_seen = 0, acc_cyc = 0;
    logic        busy = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // slave: answers AR/R or AW/W/B with programmable stalls and checks payload stability
    initial begin
        int   t;
        logic ok;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        forever begin
            @(negedge clk);
            if (arvalid && !rst) begin
                busy = 1; ar_seen++;
                check("araddr", araddr, exp_addr);
                for (int i = 0; i < ar_dly; i++) begin
                    @(negedge clk);
                    check("ar_hold", {arvalid, req_ready, araddr}, {1'b1, 1'b0, exp_addr});
                end
                arready = 1;
                @(negedge clk);
                arready = 0;
                for (int i = 0; i < r_dly; i++) @(negedge clk);
                check("rready", rready, 1);
                rvalid = 1; rdata = s_rdata; rresp = s_resp;
                @(negedge clk);
                rvalid = 0; rresp = 0;
                busy = 0;
            end else if (awvalid && !rst) begin
                busy = 1; aw_seen++;
                check("awaddr", awaddr, exp_addr);
                check("w_early", wvalid, 0);
                for (int i = 0; i < aw_dly; i++) begin
                    @(negedge clk);
                    check("aw_hold", {awvalid, wvalid, awaddr}, {1'b1, 1'b0, exp_addr});
                end
                awready = 1;
                @(negedge clk);
                awready = 0;
                t = 0;
                while (!wvalid && t < 20) begin
                    @(negedge clk);
                    t++;
                end
                check("wvalid", wvalid, 1);
                if (wvalid) begin
                    check("wdata", wdata, exp_wdata);
                    check("wstrb", wstrb, {28'b0, exp_wstrb});
                    ok = 1;
                    for (int i = 0; i < w_dly; i++) begin
                        @(negedge clk);
                        if (!wvalid) ok = 0;
                    end
                    if (ok) begin
                        wready = 1;
                        @(negedge clk);
                        wready = 0;
                        check("bready", bready, 1);
                        bvalid = 1; bresp = s_resp;
                        @(negedge clk);
                        bvalid = 0; bresp = 0;
                    end
                end
                busy = 0;
            end
        end
    end

    // monitor: pops the scoreboard on each response handshake
    logic        seen = 0, held_err;
    logic [31:0] held_rdata;
    int          first_cyc;
    exp_t        e;
    always @(negedge clk) begin
        if (resp_valid) begin
            if (!seen) begin
                seen = 1; first_cyc = cyc; held_rdata = resp_rdata; held_err = resp_err;
            end else
                check("resp_hold", {resp_rdata, resp_err}, {held_rdata, held_err});
            check("req_ready_busy", req_ready, 0);
            if (resp_ready) begin
                seen = 0;
                if (sb.size() == 0)
                    check("resp_unexpected", resp_valid, 0);
                else begin
                    e = sb.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", resp_err, e.err);
                    check("resp_latency", (first_cyc - acc_cyc) <= e.max_lat, 1);
                end
            end
        end
    end

    task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input logic uns);
        int t = 0;
        @(posedge clk); #1;
        req_wen = wen; req_addr = addr; req_wdata = wd; req_size = sz; req_unsigned = uns;
        req_valid = 1;
        while (!req_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("req_ready_wait", req_ready, 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        req_valid = 0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((sb.size() != 0 || busy) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("resp_timeout", sb.size(), 0);
        sb.delete();
    endtask

    task automatic txn(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input logic uns, input logic bus,
                       input logic [31:0] sd, input logic sr, input logic [31:0] erd,
                       input logic eerr, input int lat, input logic [31:0] ew, input logic [3:0] es);
        int t = 0;
        exp_addr = {addr[31:2], 2'b00}; exp_wdata = ew; exp_wstrb = es;
        s_rdata = sd; s_resp = sr;
        ar_seen = 0; aw_seen = 0;
        sb.push_back('{erd, eerr, lat});
        if (resp_hold > 0) resp_ready = 0;
        issue(wen, addr, wd, sz, uns);
        if (resp_hold > 0) begin
            while (!resp_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            repeat (resp_hold) @(posedge clk);
            #1 resp_ready = 1;
        end
        wait_done();
        check("ar_count", ar_seen, (bus && !wen) ? 1 : 0);
        check("aw_count", aw_seen, (bus && wen) ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t;
        rst = 1; req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0;
        req_size = 0; req_unsigned = 0; resp_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_valids", {arvalid, rready, awvalid, wvalid, bready, resp_valid}, 0);
        check("rst_addrs", {araddr, awaddr}, 0);
        check("rst_wbus", {wdata, wstrb}, 0);
        check("rst_resp", {resp_rdata, resp_err}, 0);
        @(posedge clk); #1 rst = 0;
        //   wen addr          wdata         size    uns bus slv_rdata     rr exp_rdata     err lat wdata         strb
        txn(0, 32'h80000004, 32'h0,        SZ_W,   0, 1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 2,  32'h0,        4'h0);
        txn(0, 32'h80000003, 32'h0,        SZ_B,   0, 1, 32'h80FF1234, 0, 32'hFFFFFF80, 0, 2,  32'h0,        4'h0);
        txn(0, 32'h80000003, 32'h0,        SZ_B,   1, 1, 32'h80FF1234, 0, 32'h00000080, 0, 2,  32'h0,        4'h0);
        txn(1, 32'h80000002, 32'h0000ABCD, SZ_H,   0, 1, 32'h0,        0, 32'h0,        0, 3,  32'hABCD0000, 4'hC);
        txn(1, 32'h80000001, 32'h11223344, SZ_W,   0, 0, 32'h0,        0, 32'h0,        1, 2,  32'h0,        4'h0);
        txn(0, 32'h80000001, 32'h0,        SZ_H,   0, 0, 32'h0,        0, 32'h0,        1, 2,  32'h0,        4'h0);
        txn(0, 32'h80000008, 32'h0,        SZ_W,   0, 1, 32'h0BADF00D, 1, 32'h0BADF00D, 1, 2,  32'h0,        4'h0);
        aw_dly = 2;
        txn(1, 32'h80000007, 32'h000000EE, SZ_B,   0, 1, 32'h0,        0, 32'h0,        0, 5,  32'hEE000000, 4'h8);
        aw_dly = 0;
        txn(0, 32'h8000000C, 32'h0,        2'd3,   0, 1, 32'hCAFEBABE, 0, 32'hCAFEBABE, 0, 2,  32'h0,        4'h0);
        ar_dly = 5; r_dly = 3; resp_hold = 4;
        txn(0, 32'h80000012, 32'h0,        SZ_H,   0, 1, 32'h87654321, 0, 32'hFFFF8765, 0, 100, 32'h0,       4'h0);
        ar_dly = 0; r_dly = 0; resp_hold = 0;
        txn(0, 32'h80000010, 32'h0,        SZ_H,   1, 1, 32'h87654321, 0, 32'h00004321, 0, 2,  32'h0,        4'h0);
        exp_addr = 32'h80000020; exp_wdata = 32'h55AA55AA; exp_wstrb = 4'hF; s_resp = 0;
        w_dly = 8; ar_seen = 0; aw_seen = 0;
        issue(1, 32'h80000020, 32'h55AA55AA, SZ_W, 0);
        t = 0;
        while (!wvalid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("w_reached", wvalid, 1);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("abort_wvalid", wvalid, 0);
        check("abort_req_ready", req_ready, 1);
        check("abort_resp_valid", resp_valid, 0);
        t = 0;
        while (busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("abort_aw_count", aw_seen, 1);
        w_dly = 0;
        txn(1, 32'h80000005, 32'h0000005A, SZ_B,   0, 1, 32'h0,        1, 32'h0,        1, 3,  32'h00005A00, 4'h2);
        txn(1, 32'h80000000, 32'h01020304, SZ_W,   0, 1, 32'h0,        0, 32'h0,        0, 3,  32'h01020304, 4'hF);
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
